// File: rtl/signal_order_manager_if.sv
// signal_order_manager_if: order payload and valid/ready handshake toward the order-egress block
interface signal_order_manager_if;
  logic       order_valid;
  logic       order_ready;
  logic       order_side;
  logic [7:0] order_price;
  logic [7:0] order_qty;
  modport master (output order_valid, order_side, order_price, order_qty, input order_ready);
  modport slave  (input order_valid, order_side, order_price, order_qty, output order_ready);
endinterface

// File: rtl/signal_order_manager.sv
// signal_order_manager: confirms persistent buy/sell signals, issues one position-limited order at a time, then cools down; define ORDER_STATS_EN for buy/sell/reject counters
module signal_order_manager #(
  parameter int CONFIRM   = 2,
  parameter int COOLDOWN  = 8,
  parameter int ORDER_QTY = 1,
  parameter int POS_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [7:0]            price,
  signal_order_manager_if.master ord,
  output logic [7:0]            position,
  output logic                  busy
`ifdef ORDER_STATS_EN
  ,
  output logic [15:0]           buy_count,
  output logic [15:0]           sell_count,
  output logic [15:0]           reject_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COOL} state_t;
  localparam logic signed [8:0] QTY9 = 9'(ORDER_QTY);
  localparam logic signed [8:0] LIM9 = 9'(POS_LIMIT);
  state_t             r_state;
  logic [3:0]         r_run;
  logic               r_last;
  logic [7:0]         r_cd;
  logic               r_valid;
  logic               r_side;
  logic [7:0]         r_price;
  logic [7:0]         r_qty;
  logic [7:0]         r_pos;
  logic               r_busy;
  logic signed [8:0]  w_pos9;
  logic               w_buy_q;
  logic               w_sell_q;
  logic               w_q;
  logic [3:0]         w_run_nxt;
  logic               w_fire;
  assign w_pos9    = {r_pos[7], r_pos};
  assign w_buy_q   = buy_signal && !sell_signal && ((w_pos9 + QTY9) <= LIM9);
  assign w_sell_q  = sell_signal && !buy_signal && ((w_pos9 - QTY9) >= -LIM9);
  assign w_q       = w_buy_q || w_sell_q;
  assign w_run_nxt = !w_q ? 4'd0 : (w_sell_q == r_last) ? r_run + 4'd1 : 4'd1;
  assign w_fire    = w_run_nxt == 4'(CONFIRM);
  assign ord.order_valid = r_valid;
  assign ord.order_side  = r_side;
  assign ord.order_price = r_price;
  assign ord.order_qty   = r_qty;
  assign position        = r_pos;
  assign busy            = r_busy;
  // Order FSM: confirm run in IDLE, hold payload until handshake, then count down the cooldown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_run   <= '0;
      r_last  <= 1'b0;
      r_cd    <= '0;
      r_valid <= 1'b0;
      r_side  <= 1'b0;
      r_price <= '0;
      r_qty   <= '0;
      r_pos   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_q) r_last <= w_sell_q;
          r_run <= w_fire ? 4'd0 : w_run_nxt;
          if (w_fire) begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_side  <= w_sell_q;
            r_price <= price;
            r_qty   <= 8'(ORDER_QTY);
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ord.order_ready) begin
            r_valid <= 1'b0;
            r_qty   <= '0;
            r_pos   <= r_side ? r_pos - 8'(ORDER_QTY) : r_pos + 8'(ORDER_QTY);
            r_cd    <= 8'(COOLDOWN);
            r_state <= (COOLDOWN == 0) ? S_IDLE : S_COOL;
            r_busy  <= COOLDOWN != 0;
          end
        end
        S_COOL: begin
          r_cd <= r_cd - 8'd1;
          if (r_cd == 8'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef ORDER_STATS_EN
  logic w_hs;
  logic w_reject;
  assign w_hs     = (r_state == S_ISSUE) && ord.order_ready;
  assign w_reject = (r_state == S_IDLE) && (buy_signal ^ sell_signal) && !w_q;
  // Statistics: accepted orders per side and limit-blocked single-signal cycles, all wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buy_count    <= '0;
      sell_count   <= '0;
      reject_count <= '0;
    end else begin
      if (w_hs && !r_side) buy_count <= buy_count + 16'd1;
      if (w_hs && r_side) sell_count <= sell_count + 16'd1;
      if (w_reject) reject_count <= reject_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_signal_order_manager.sv
// tb_signal_order_manager: table-driven vectors with an order scoreboard plus hand-written multi-cycle sequences
module tb_signal_order_manager;
  logic       clk;
  logic       rst;
  logic       buy_signal;
  logic       sell_signal;
  logic [7:0] price;
  logic [7:0] position;
  logic       busy;
`ifdef ORDER_STATS_EN
  logic [15:0] buy_count, sell_count, reject_count;
`endif
  signal_order_manager_if ord();
  signal_order_manager dut (
    .clk(clk), .rst(rst), .buy_signal(buy_signal), .sell_signal(sell_signal),
    .price(price), .ord(ord), .position(position), .busy(busy)
`ifdef ORDER_STATS_EN
    , .buy_count(buy_count), .sell_count(sell_count), .reject_count(reject_count)
`endif
  );
  typedef struct {
    logic       buy;
    logic       sell;
    logic [7:0] pr;
    int         hold;
    int         wait_n;
    logic       exp_order;
    logic       exp_side;
    logic [7:0] exp_pos;
  } vec_t;
  typedef struct {
    logic       side;
    logic [7:0] pr;
    logic [7:0] qty;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[11];
  int   n_vec = 0;
  int   n_bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_payload();
    exp_t e;
    chk("sb_pending", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("side", ord.order_side, e.side);
      chk("price", ord.order_price, e.pr);
      chk("qty", ord.order_qty, e.qty);
    end
  endtask
  task automatic apply(input vec_t v);
    int n;
    buy_signal  = v.buy;
    sell_signal = v.sell;
    price       = v.pr;
    if (v.exp_order) sb.push_back('{v.exp_side, v.pr, 8'd1});
    repeat (v.hold) tick();
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    chk("valid", ord.order_valid, v.exp_order);
    if (ord.order_valid) begin
      price = v.pr + 8'd20;
      for (int i = 0; i < v.wait_n; i++) begin
        tick();
        chk("hold_valid", ord.order_valid, 1);
        chk("hold_price", ord.order_price, v.pr);
      end
      check_payload();
      ord.order_ready = 1'b1;
      tick();
      ord.order_ready = 1'b0;
      chk("valid_drop", ord.order_valid, 0);
      chk("qty_zero", ord.order_qty, 0);
      n = 0;
      while (busy && n < 300) begin
        tick();
        n++;
      end
      chk("cooldown_len", n, 8);
    end else begin
      repeat (2) tick();
    end
    chk("position", position, v.exp_pos);
  endtask
  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b0, 8'd100, 2, 0, 1'b1, 1'b0, 8'd1};
    tbl[1]  = '{1'b1, 1'b1, 8'd100, 5, 0, 1'b0, 1'b0, 8'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'd50,  2, 4, 1'b1, 1'b1, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'd33,  1, 0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'd10,  2, 0, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 8'd20,  2, 1, 1'b1, 1'b0, 8'd2};
    tbl[6]  = '{1'b1, 1'b0, 8'd30,  2, 0, 1'b1, 1'b0, 8'd3};
    tbl[7]  = '{1'b1, 1'b0, 8'd40,  2, 2, 1'b1, 1'b0, 8'd4};
    tbl[8]  = '{1'b1, 1'b0, 8'd55,  4, 0, 1'b0, 1'b0, 8'd4};
    tbl[9]  = '{1'b0, 1'b1, 8'd77,  2, 0, 1'b1, 1'b1, 8'd3};
    tbl[10] = '{1'b0, 1'b1, 8'd60,  2, 0, 1'b1, 1'b1, 8'd2};
    rst = 1'b0;
    buy_signal = 1'b0;
    sell_signal = 1'b0;
    price = 8'd0;
    ord.order_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", ord.order_valid, 0);
    chk("rst_side", ord.order_side, 0);
    chk("rst_price", ord.order_price, 0);
    chk("rst_qty", ord.order_qty, 0);
    chk("rst_pos", position, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) apply(tbl[i]);
`ifdef ORDER_STATS_EN
    chk("reject_count", reject_count, 4);
`endif
    buy_signal = 1'b1; tick();
    buy_signal = 1'b0; tick();
    chk("gap_valid", ord.order_valid, 0);
    buy_signal = 1'b1; tick();
    buy_signal = 1'b0;
    chk("gap_valid2", ord.order_valid, 0);
    tick();
    chk("gap_valid3", ord.order_valid, 0);
    chk("gap_pos", position, 2);
    price = 8'd90;
    sell_signal = 1'b1;
    sb.push_back('{1'b1, 8'd90, 8'd1});
    repeat (2) tick();
    chk("held_valid", ord.order_valid, 1);
    check_payload();
    ord.order_ready = 1'b1;
    tick();
    ord.order_ready = 1'b0;
    n = 0;
    while (!ord.order_valid && n < 50) begin
      tick();
      n++;
    end
    chk("reconfirm_gap", n, 10);
    sb.push_back('{1'b1, 8'd90, 8'd1});
    check_payload();
    sell_signal = 1'b0;
    tick();
    chk("issue_pos", position, 1);
    chk("issue_valid", ord.order_valid, 1);
`ifdef ORDER_STATS_EN
    chk("buy_count", buy_count, 5);
    chk("sell_count", sell_count, 4);
`endif
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", ord.order_valid, 0);
    chk("arst_pos", position, 0);
    chk("arst_busy", busy, 0);
    chk("arst_qty", ord.order_qty, 0);
`ifdef ORDER_STATS_EN
    chk("arst_stats", {buy_count, sell_count}, 0);
`endif
    tick();
    #2 rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    apply('{1'b1, 1'b0, 8'd200, 2, 0, 1'b1, 1'b0, 8'd1});
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
